// File: rtl/hazard_sequencer_pkg.sv
// Shared RV32I definitions for the hazard sequencer: opcodes, FSM state
// encoding and instruction field-slice helpers.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } hz_state_t;

    function automatic logic [4:0] rs1_of(input logic [31:0] ir);
        return ir[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] ir);
        return ir[24:20];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] ir);
        return ir[11:7];
    endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline <-> hazard sequencer bundle. The master side is the pipeline
// (presents instructions and memory status), the slave side is the sequencer
// (returns forwarding, stall, flush and status).
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
) ();

    logic [31:0]      ir_if;
    logic [31:0]      ir_ex;
    logic             ex_wren;
    logic             br_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             fwd_a;
    logic             fwd_b;
    logic             stall_if;
    logic             stall_ex;
    logic             flush;
    logic             bubble_ex;
    logic             mem_err;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ir_if, ir_ex, ex_wren, br_taken, dmem_req, dmem_ready,
        input  fwd_a, fwd_b, stall_if, stall_ex, flush, bubble_ex,
               mem_err, state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  ir_if, ir_ex, ex_wren, br_taken, dmem_req, dmem_ready,
        output fwd_a, fwd_b, stall_if, stall_ex, flush, bubble_ex,
               mem_err, state_o, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, hold once every bit is set, clear synchronously.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Prioritised hazard sequencer for the RV32I IF/EX pipeline: operand
// forwarding, load-use bubbles, branch flushes and data-memory wait stalls
// with a timeout, plus saturating stall/flush event counters.
module hazard_sequencer
    import rv_pkg::*;
#(
    parameter int FLUSH_CYCLES      = 1,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_sequencer_if.slave bus
);

    localparam logic [2:0] FLUSH_REST = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] FLUSH_FULL = 3'(FLUSH_CYCLES);
    localparam logic [2:0] LOAD_REST  = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    logic [4:0] rd_ex_s;
    logic       is_load_s;
    logic       hit_rs1_s;
    logic       hit_rs2_s;
    logic       load_use_s;
    logic       mem_wait_s;
    logic [7:0] wait_next_s;

    hz_state_t  state_r;
    logic [2:0] cnt_r;
    logic [7:0] wait_cnt_r;
    logic       pending_flush_r;
    logic       mem_err_r;

    logic       fwd_a_s;
    logic       fwd_b_s;
    logic       stall_if_s;
    logic       stall_ex_s;
    logic       flush_s;
    logic       bubble_ex_s;

    logic [CNT_W-1:0] stall_cnt_s;
    logic [CNT_W-1:0] flush_cnt_s;

    assign rs1_s       = rs1_of(bus.ir_if);
    assign rs2_s       = rs2_of(bus.ir_if);
    assign rd_ex_s     = rd_of(bus.ir_ex);
    assign is_load_s   = (bus.ir_ex[6:0] == OP_LOAD);
    assign hit_rs1_s   = bus.ex_wren && (rd_ex_s != 5'd0) && (rs1_s == rd_ex_s);
    assign hit_rs2_s   = bus.ex_wren && (rd_ex_s != 5'd0) && (rs2_s == rd_ex_s);
    assign load_use_s  = is_load_s && (hit_rs1_s || hit_rs2_s);
    assign mem_wait_s  = bus.dmem_req && !bus.dmem_ready;
    assign wait_next_s = wait_cnt_r + 8'd1;

    // Decode the pipeline-control outputs from the current state and inputs.
    always_comb begin
        fwd_a_s     = 1'b0;
        fwd_b_s     = 1'b0;
        stall_if_s  = 1'b0;
        stall_ex_s  = 1'b0;
        flush_s     = 1'b0;
        bubble_ex_s = 1'b0;
        case (state_r)
            RUN: begin
                fwd_a_s = hit_rs1_s && !is_load_s;
                fwd_b_s = hit_rs2_s && !is_load_s;
                if (mem_wait_s) begin
                    stall_if_s = 1'b1;
                    stall_ex_s = 1'b1;
                end else if (bus.br_taken) begin
                    flush_s = 1'b1;
                end else if (load_use_s) begin
                    stall_if_s  = 1'b1;
                    bubble_ex_s = 1'b1;
                end else begin
                    stall_if_s = 1'b0;
                end
            end
            LOAD_STALL: begin
                if (bus.br_taken) begin
                    flush_s = 1'b1;
                end else begin
                    stall_if_s  = 1'b1;
                    bubble_ex_s = 1'b1;
                end
            end
            MEM_WAIT: begin
                stall_if_s = 1'b1;
                stall_ex_s = 1'b1;
            end
            FLUSH: begin
                flush_s    = 1'b1;
                stall_if_s = 1'b1;
            end
            default: begin
                flush_s = 1'b0;
            end
        endcase
    end

    // Sequencer FSM: hold-cycle counters, pending flush and sticky timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= RUN;
            cnt_r           <= 3'd0;
            wait_cnt_r      <= 8'd0;
            pending_flush_r <= 1'b0;
            mem_err_r       <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_wait_s) begin
                        state_r         <= MEM_WAIT;
                        wait_cnt_r      <= 8'd1;
                        pending_flush_r <= bus.br_taken;
                    end else if (bus.br_taken) begin
                        state_r <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                        cnt_r   <= FLUSH_REST;
                    end else if (load_use_s) begin
                        state_r <= (LOAD_STALL_CYCLES > 1) ? LOAD_STALL : RUN;
                        cnt_r   <= LOAD_REST;
                    end else begin
                        state_r <= RUN;
                    end
                end
                LOAD_STALL: begin
                    if (bus.br_taken) begin
                        state_r <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                        cnt_r   <= FLUSH_REST;
                    end else if (cnt_r == 3'd1) begin
                        state_r <= RUN;
                        cnt_r   <= 3'd0;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                MEM_WAIT: begin
                    wait_cnt_r <= wait_next_s;
                    if (bus.dmem_ready) begin
                        if (pending_flush_r) begin
                            state_r <= FLUSH;
                            cnt_r   <= FLUSH_FULL;
                        end else begin
                            state_r <= RUN;
                        end
                        pending_flush_r <= 1'b0;
                    end else if (wait_next_s == TIMEOUT) begin
                        // Give up on the access; a flush owed to it is lost too.
                        mem_err_r       <= 1'b1;
                        pending_flush_r <= 1'b0;
                        state_r         <= RUN;
                    end else begin
                        state_r <= MEM_WAIT;
                    end
                end
                FLUSH: begin
                    if (cnt_r == 3'd1) begin
                        state_r <= RUN;
                        cnt_r   <= 3'd0;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (stall_if_s && !flush_s),
        .count (stall_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (flush_s),
        .count (flush_cnt_s)
    );

    assign bus.fwd_a     = fwd_a_s;
    assign bus.fwd_b     = fwd_b_s;
    assign bus.stall_if  = stall_if_s;
    assign bus.stall_ex  = stall_ex_s;
    assign bus.flush     = flush_s;
    assign bus.bubble_ex = bubble_ex_s;
    assign bus.mem_err   = mem_err_r;
    assign bus.state_o   = state_r;
    assign bus.stall_cnt = stall_cnt_s;
    assign bus.flush_cnt = flush_cnt_s;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: each cycle the expected outputs
// are pushed into a scoreboard queue when the inputs are driven and popped
// and compared on the falling edge.
module tb_hazard_sequencer;
    import rv_pkg::*;

    localparam int FLUSH_C = 3;
    localparam int LOAD_C  = 2;
    localparam int TMO     = 8;
    localparam int CW      = 16;

    // ctrl vector bit order: {fwd_a, fwd_b, stall_if, stall_ex, flush, bubble_ex, mem_err}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_FWD2 = 7'b1100000;
    localparam logic [6:0] C_FWDA = 7'b1000000;
    localparam logic [6:0] C_LU   = 7'b0010010;
    localparam logic [6:0] C_BR   = 7'b0000100;
    localparam logic [6:0] C_FL   = 7'b0010100;
    localparam logic [6:0] C_MW   = 7'b0011000;
    localparam logic [6:0] C_ERR  = 7'b0000001;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [6:0]    ctrl;
        logic [1:0]    st;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_stall;
    int   exp_flush;
    exp_t sb_q[$];

    hazard_sequencer_if #(.CNT_W(CW)) bus ();

    hazard_sequencer #(
        .FLUSH_CYCLES      (FLUSH_C),
        .LOAD_STALL_CYCLES (LOAD_C),
        .MEM_TIMEOUT       (TMO),
        .CNT_W             (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] r_sub(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pipeline cycle: drive inputs, push expectation, compare on negedge.
    task automatic step(input string tag, input logic [31:0] iif, input logic [31:0] iex,
                        input logic wren, input logic br, input logic req, input logic rdy,
                        input logic [6:0] ctrl, input hz_state_t st);
        exp_t e;
        exp_t q;
        bus.ir_if      = iif;
        bus.ir_ex      = iex;
        bus.ex_wren    = wren;
        bus.br_taken   = br;
        bus.dmem_req   = req;
        bus.dmem_ready = rdy;
        e.ctrl = ctrl;
        e.st   = st;
        e.sc   = CW'(exp_stall);
        e.fc   = CW'(exp_flush);
        sb_q.push_back(e);
        if (ctrl[4] && !ctrl[2]) exp_stall++;
        if (ctrl[2]) exp_flush++;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_value({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            q = sb_q.pop_front();
            check_value({tag, ".ctrl"}, 32'({bus.fwd_a, bus.fwd_b, bus.stall_if, bus.stall_ex,
                                             bus.flush, bus.bubble_ex, bus.mem_err}), 32'(q.ctrl));
            check_value({tag, ".state"}, 32'(bus.state_o), 32'(q.st));
            check_value({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(q.sc));
            check_value({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(q.fc));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.ir_if      = NOP;
        bus.ir_ex      = NOP;
        bus.ex_wren    = 1'b0;
        bus.br_taken   = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_stall = 0;
        exp_flush = 0;
        rst_n     = 1'b0;
        bus.ir_if = NOP; bus.ir_ex = NOP; bus.ex_wren = 1'b0; bus.br_taken = 1'b0;
        bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        step("reset", NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, RUN);

        // ALU forwarding and the qualifiers that suppress it.
        step("fwd_ab", r_sub(5'd6, 5'd5, 5'd5), r_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, C_FWD2, RUN);
        step("fwd_a", r_add(5'd9, 5'd5, 5'd3), r_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, C_FWDA, RUN);
        step("no_wren", r_sub(5'd6, 5'd5, 5'd5), r_add(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, RUN);
        step("x0_guard", r_add(5'd6, 5'd0, 5'd0), r_add(5'd0, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, RUN);

        // Load-use: LOAD_C bubbles, then the load has left EX.
        step("lu_0", r_add(5'd8, 5'd7, 5'd1), i_lw(5'd7, 5'd3), 1'b1, 1'b0, 1'b0, 1'b0, C_LU, RUN);
        step("lu_1", r_add(5'd8, 5'd7, 5'd1), NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, LOAD_STALL);
        step("lu_done", r_add(5'd8, 5'd7, 5'd1), NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, RUN);

        // Branch beats load-use; branches during FLUSH are ignored.
        step("br_0", r_add(5'd8, 5'd7, 5'd1), i_lw(5'd7, 5'd3), 1'b1, 1'b1, 1'b0, 1'b0, C_BR, RUN);
        step("br_1", NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, C_FL, FLUSH);
        step("br_2", NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, C_FL, FLUSH);
        step("br_done", NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, RUN);

        // Branch arriving during a load stall takes over immediately.
        step("lubr_0", r_add(5'd8, 5'd1, 5'd7), i_lw(5'd7, 5'd3), 1'b1, 1'b0, 1'b0, 1'b0, C_LU, RUN);
        step("lubr_1", NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, C_BR, LOAD_STALL);
        step("lubr_2", NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_FL, FLUSH);
        step("lubr_3", NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_FL, FLUSH);
        step("lubr_done", NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, RUN);

        // Memory wait with a branch in its first cycle: 6 stalled cycles then a full flush.
        step("mwbr_0", NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b0, C_MW, RUN);
        for (int i = 0; i < 4; i++)
            step("mwbr_wait", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, C_MW, MEM_WAIT);
        step("mwbr_ready", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b1, C_MW, MEM_WAIT);
        for (int i = 0; i < FLUSH_C; i++)
            step("mwbr_flush", NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_FL, FLUSH);
        step("mwbr_done", NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, RUN);

        // Plain memory wait returns straight to RUN.
        step("mw_0", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, C_MW, RUN);
        step("mw_ready", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b1, C_MW, MEM_WAIT);
        step("mw_done", NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, RUN);

        // Timeout after TMO waiting cycles; the pending flush is dropped.
        step("tmo_0", NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b0, C_MW, RUN);
        for (int i = 0; i < TMO - 1; i++)
            step("tmo_wait", NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, C_MW, MEM_WAIT);
        step("tmo_err", NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_ERR, RUN);
        step("tmo_sticky", r_sub(5'd6, 5'd5, 5'd5), r_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0, C_FWD2 | C_ERR, RUN);

        // Reset in the middle of a memory wait with a pending flush.
        step("rst_mid", NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b0, C_MW | C_ERR, RUN);
        do_reset();
        step("rst_after", NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, RUN);
        step("rst_idle", NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, RUN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
